// File: rtl/osc_ui_pkg.sv
// Shared types and default parameter sets for the oscilloscope mouse UI.
// Packed per-channel vectors hold channel 0 in the LSBs.
package osc_ui_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } ui_state_t;

    localparam int CH_TRIG_CLK = 0;
    localparam int CH_TRIG     = 1;
    localparam int CH_ADC      = 2;

    localparam logic [3*12-1:0] ZONE_EDGE_DEF = {12'd1000, 12'd700, 12'd300};
    localparam logic [3*19-1:0] INIT_DEF      = {19'h00800, 19'h1B580, 19'h01F80};
    localparam logic [3*12-1:0] VMIN_DEF      = {12'd13, 12'd0, 12'd0};
    localparam logic [3*12-1:0] VMAX_DEF      = {12'd4095, 12'd2054, 12'd4095};

endpackage

// File: rtl/sat_step.sv
// One signed add/clamp of a fixed-point accumulator against integer limits.
// Reports whether the result had to be clamped.
module sat_step #(
    parameter int VAL_W  = 12,
    parameter int FRAC_W = 7,
    parameter int COARSE = 10
) (
    input  logic [VAL_W+FRAC_W-1:0] i_acc,
    input  logic                    i_up,
    input  logic                    i_coarse,
    input  logic [VAL_W-1:0]        i_vmin,
    input  logic [VAL_W-1:0]        i_vmax,
    output logic [VAL_W+FRAC_W-1:0] o_acc,
    output logic                    o_clamped
);

    localparam int ACC_W = VAL_W + FRAC_W;
    localparam int SUM_W = ACC_W + 2;

    logic signed [SUM_W-1:0] w_cur;
    logic signed [SUM_W-1:0] w_mag;
    logic signed [SUM_W-1:0] w_sum;
    logic signed [SUM_W-1:0] w_lo;
    logic signed [SUM_W-1:0] w_hi;

    always_comb begin
        w_cur = $signed({2'b00, i_acc});
        w_mag = i_coarse ? SUM_W'(COARSE) : SUM_W'(1);
        w_lo  = $signed({2'b00, i_vmin, {FRAC_W{1'b0}}});
        w_hi  = $signed({2'b00, i_vmax, {FRAC_W{1'b1}}});
        w_sum = i_up ? (w_cur + w_mag) : (w_cur - w_mag);
        // NOTE: outputs get a default before the branches so no latch is inferred.
        o_acc     = w_sum[ACC_W-1:0];
        o_clamped = 1'b0;
        if (w_sum < w_lo) begin
            o_acc     = w_lo[ACC_W-1:0];
            o_clamped = 1'b1;
        end else if (w_sum > w_hi) begin
            o_acc     = w_hi[ACC_W-1:0];
            o_clamped = 1'b1;
        end
    end

endmodule

// File: rtl/mouse_param_ctrl.sv
// Mouse-driven fixed-point setting accumulators: zone select, saturating steps,
// repeat lockout with early release, and step/saturation status.
module mouse_param_ctrl
    import osc_ui_pkg::*;
#(
    parameter int                          N_CH      = 3,
    parameter int                          VAL_W     = 12,
    parameter int                          FRAC_W    = 7,
    parameter int                          COARSE    = 10,
    parameter int                          HOLD_CYC  = 100_000,
    parameter logic [N_CH*12-1:0]          ZONE_EDGE = ZONE_EDGE_DEF,
    parameter int                          Y_MIN     = 0,
    parameter int                          Y_MAX     = 4095,
    parameter logic [N_CH*(VAL_W+FRAC_W)-1:0] INIT   = INIT_DEF,
    parameter logic [N_CH*VAL_W-1:0]       VMIN      = VMIN_DEF,
    parameter logic [N_CH*VAL_W-1:0]       VMAX      = VMAX_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        left_mouse,
    input  logic                        right_mouse,
    input  logic                        middle_mouse,
    input  logic [11:0]                 xpos,
    input  logic [11:0]                 ypos,
    output logic [N_CH*VAL_W-1:0]       value,
    output logic [$clog2(N_CH+1)-1:0]   active_ch,
    output logic                        step_pulse,
    output logic [N_CH-1:0]             sat_flag
);

    localparam int ACC_W = VAL_W + FRAC_W;
    localparam int CH_W  = $clog2(N_CH + 1);
    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CNT_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    ui_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [ACC_W-1:0] r_acc [N_CH];
    logic             r_pulse;
    logic [N_CH-1:0]  r_sat;

    logic [12:0]      w_yrel;
    logic             w_yin;
    logic [CH_W-1:0]  w_zone;
    logic [IDX_W-1:0] w_sel;
    logic             w_req;
    logic [VAL_W-1:0] w_vmin;
    logic [VAL_W-1:0] w_vmax;
    logic [ACC_W-1:0] w_acc_next;
    logic             w_clamped;

    always_comb begin
        // Window test as one unsigned range check; ypos below Y_MIN wraps high.
        w_yrel = {1'b0, ypos} - 13'(Y_MIN);
        w_yin  = (w_yrel <= 13'(Y_MAX - Y_MIN));
        w_zone = CH_W'(N_CH);
        if (w_yin) begin
            for (int k = N_CH - 1; k >= 0; k--) begin
                if (xpos < ZONE_EDGE[k*12 +: 12]) w_zone = CH_W'(k);
            end
        end
        w_sel  = (w_zone < CH_W'(N_CH)) ? IDX_W'(w_zone) : '0;
        w_req  = (left_mouse ^ right_mouse) && (w_zone < CH_W'(N_CH));
        w_vmin = VMIN[w_sel*VAL_W +: VAL_W];
        w_vmax = VMAX[w_sel*VAL_W +: VAL_W];
    end

    sat_step #(
        .VAL_W  (VAL_W),
        .FRAC_W (FRAC_W),
        .COARSE (COARSE)
    ) u_sat_step (
        .i_acc     (r_acc[w_sel]),
        .i_up      (right_mouse),
        .i_coarse  (middle_mouse),
        .i_vmin    (w_vmin),
        .i_vmax    (w_vmax),
        .o_acc     (w_acc_next),
        .o_clamped (w_clamped)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_pulse <= 1'b0;
            r_sat   <= '0;
            // NOTE: the accumulator bank is reset because each entry must start at its INIT value.
            for (int k = 0; k < N_CH; k++) r_acc[k] <= INIT[k*ACC_W +: ACC_W];
        end else begin
            // NOTE: non-blocking assignments so every branch sees the pre-edge state.
            r_pulse <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_acc[w_sel] <= w_acc_next;
                        r_sat[w_sel] <= w_clamped;
                        r_pulse      <= 1'b1;
                        r_cnt        <= '0;
                        r_state      <= LOCK;
                    end
                end
                LOCK: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (!left_mouse && !right_mouse) begin
                        r_state <= IDLE;
                    end else if (r_cnt == CNT_W'(HOLD_CYC - 1)) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_value
        assign value[k*VAL_W +: VAL_W] = r_acc[k][ACC_W-1:FRAC_W];
    end

    assign active_ch  = w_zone;
    assign step_pulse = r_pulse;
    assign sat_flag   = r_sat;

endmodule

// File: tb/tb_mouse_param_ctrl.sv
// Bench for mouse_param_ctrl: two instances (default window, and a preset
// near-limit channel with a narrowed y-window) checked against a reference model.
module tb_mouse_param_ctrl;
    import osc_ui_pkg::*;

    localparam int HOLD = 10;
    localparam logic [56:0] INIT_B = {19'h00800, 19'h4037A, 19'h01F80};

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        lm    = 1'b0;
    logic        rm    = 1'b0;
    logic        mm    = 1'b0;
    logic [11:0] xpos  = 12'd2000;
    logic [11:0] ypos  = 12'd2000;

    logic [35:0] value_a, value_b;
    logic [1:0]  act_a, act_b;
    logic        pulse_a, pulse_b;
    logic [2:0]  sat_a, sat_b;

    logic [35:0] dv  [2];
    logic [1:0]  dact[2];
    logic        dpul[2];
    logic [2:0]  dsat[2];
    assign dv[0] = value_a;   assign dv[1] = value_b;
    assign dact[0] = act_a;   assign dact[1] = act_b;
    assign dpul[0] = pulse_a; assign dpul[1] = pulse_b;
    assign dsat[0] = sat_a;   assign dsat[1] = sat_b;

    mouse_param_ctrl #(.HOLD_CYC(HOLD)) u_dut_a (
        .clk(clk), .rst(rst), .left_mouse(lm), .right_mouse(rm), .middle_mouse(mm),
        .xpos(xpos), .ypos(ypos), .value(value_a), .active_ch(act_a),
        .step_pulse(pulse_a), .sat_flag(sat_a)
    );

    mouse_param_ctrl #(.HOLD_CYC(HOLD), .INIT(INIT_B), .Y_MIN(100), .Y_MAX(3000)) u_dut_b (
        .clk(clk), .rst(rst), .left_mouse(lm), .right_mouse(rm), .middle_mouse(mm),
        .xpos(xpos), .ypos(ypos), .value(value_b), .active_ch(act_b),
        .step_pulse(pulse_b), .sat_flag(sat_b)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int ncyc  = 0;
    int cnt [2];
    int plog [$];

    // Reference model: integer accumulators, limits in output units, and a
    // remaining-lockout count that a release cuts short.
    int m_init [2][3];
    int m_vmin [3];
    int m_vmax [3];
    int m_ymin [2];
    int m_ymax [2];
    int m_acc  [2][3];
    bit m_sat  [2][3];
    int m_lock [2];
    bit m_pulse[2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int zone(int d);
        if (int'(ypos) < m_ymin[d] || int'(ypos) > m_ymax[d]) return 3;
        if (xpos < 12'd300)  return 0;
        if (xpos < 12'd700)  return 1;
        if (xpos < 12'd1000) return 2;
        return 3;
    endfunction

    task automatic model_reset(int d);
        for (int k = 0; k < 3; k++) begin
            m_acc[d][k] = m_init[d][k];
            m_sat[d][k] = 1'b0;
        end
        m_lock[d]  = 0;
        m_pulse[d] = 1'b0;
    endtask

    task automatic model_edge(int d);
        int z, nv, lo, hi, delta;
        m_pulse[d] = 1'b0;
        if (m_lock[d] > 0) begin
            if (!lm && !rm) m_lock[d] = 0;
            else            m_lock[d] = m_lock[d] - 1;
        end else begin
            z = zone(d);
            if ((lm != rm) && z < 3) begin
                delta = mm ? 10 : 1;
                if (lm) delta = -delta;
                nv = m_acc[d][z] + delta;
                lo = m_vmin[z] * 128;
                hi = m_vmax[z] * 128 + 127;
                m_sat[d][z] = (nv < lo) || (nv > hi);
                if (nv < lo) nv = lo;
                if (nv > hi) nv = hi;
                m_acc[d][z] = nv;
                m_pulse[d]  = 1'b1;
                m_lock[d]   = HOLD;
            end
        end
    endtask

    task automatic compare_all();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 3; k++) begin
                check($sformatf("value%0d[%0d]", d, k), 32'(dv[d][k*12 +: 12]), 32'(m_acc[d][k] >> 7));
                check($sformatf("sat%0d[%0d]", d, k), 32'(dsat[d][k]), 32'(m_sat[d][k]));
            end
            check($sformatf("pulse%0d", d), 32'(dpul[d]), 32'(m_pulse[d]));
            check($sformatf("active%0d", d), 32'(dact[d]), 32'(zone(d)));
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (rst) model_reset(d);
            else     model_edge(d);
        end
        #1;
        ncyc++;
        cnt[0] += int'(pulse_a);
        cnt[1] += int'(pulse_b);
        if (pulse_a) plog.push_back(ncyc);
        compare_all();
    endtask

    task automatic set_btn(input logic l, input logic r, input logic m);
        lm = l; rm = r; mm = m;
    endtask

    task automatic click(input logic l, input logic r, input logic m, input int hi, input int lo);
        set_btn(l, r, m);
        repeat (hi) cyc();
        set_btn(1'b0, 1'b0, 1'b0);
        repeat (lo) cyc();
    endtask

    initial begin
        int n;
        m_init = '{'{'h1F80, 'h1B580, 'h800}, '{'h1F80, 'h4037A, 'h800}};
        m_vmin = '{0, 0, 13};
        m_vmax = '{4095, 2054, 4095};
        m_ymin = '{0, 100};
        m_ymax = '{4095, 3000};
        cnt    = '{0, 0};
        for (int d = 0; d < 2; d++) model_reset(d);

        // Reset state
        repeat (3) cyc();
        check("rst_val_a0", 32'(value_a[11:0]), 32'd63);
        check("rst_val_a1", 32'(value_a[23:12]), 32'd875);
        check("rst_val_a2", 32'(value_a[35:24]), 32'd16);
        check("rst_pulse_a", 32'(pulse_a), 32'd0);
        check("rst_sat_a", 32'(sat_a), 32'd0);
        check("rst_act_a", 32'(act_a), 32'd3);
        rst = 1'b0;
        repeat (2) cyc();

        // Coarse step into the upper limit of the preset channel
        xpos = 12'd500; ypos = 12'd2000;
        cnt = '{0, 0};
        click(1'b0, 1'b1, 1'b1, 3, 2);
        check("preset_val_b1", 32'(value_b[23:12]), 32'd2054);
        check("preset_sat_b1", 32'(sat_b[1]), 32'd1);
        check("preset_pulses_b", 32'(cnt[1]), 32'd1);
        check("coarse_val_a1", 32'(value_a[23:12]), 32'd875);

        // Fine clicks: 0x1B58A + 117 = 0x1B5FF, one more crosses to 876
        cnt = '{0, 0};
        click(1'b0, 1'b1, 1'b0, 3, 2);
        check("click_pulses_a", 32'(cnt[0]), 32'd1);
        repeat (116) click(1'b0, 1'b1, 1'b0, 3, 2);
        check("click117_val_a1", 32'(value_a[23:12]), 32'd875);
        click(1'b0, 1'b1, 1'b0, 3, 2);
        check("click118_val_a1", 32'(value_a[23:12]), 32'd876);
        repeat (10) click(1'b0, 1'b1, 1'b0, 3, 2);
        check("click128_pulses_a", 32'(cnt[0]), 32'd128);

        // Held button auto-repeat
        xpos = 12'd100;
        cnt = '{0, 0};
        plog.delete();
        set_btn(1'b0, 1'b1, 1'b0);
        repeat (55) cyc();
        set_btn(1'b0, 1'b0, 1'b0);
        repeat (3) cyc();
        check("hold_pulses_a", 32'(cnt[0]), 32'd5);
        for (int i = 1; i < plog.size(); i++) check("hold_gap_a", 32'(plog[i] - plog[i-1]), 32'd11);
        check("hold_val_a0", 32'(value_a[11:0]), 32'd63);

        // Coarse decrement down to the lower limit
        xpos = 12'd800;
        n = 0;
        while (!m_sat[0][2] && n < 60) begin
            click(1'b1, 1'b0, 1'b1, 3, 2);
            n++;
        end
        check("clamp_lo_clicks", 32'(n), 32'd39);
        check("clamp_lo_val_a2", 32'(value_a[35:24]), 32'd13);
        check("clamp_lo_sat_a2", 32'(sat_a[2]), 32'd1);
        click(1'b0, 1'b1, 1'b0, 3, 2);
        check("unclamp_sat_a2", 32'(sat_a[2]), 32'd0);

        // Requests that must not step
        xpos = 12'd500;
        cnt = '{0, 0};
        click(1'b1, 1'b1, 1'b0, 5, 2);
        check("both_btn_pulses_a", 32'(cnt[0]), 32'd0);
        xpos = 12'd1100;
        click(1'b0, 1'b1, 1'b0, 3, 2);
        check("far_x_act_a", 32'(act_a), 32'd3);
        check("far_x_pulses_a", 32'(cnt[0]), 32'd0);
        xpos = 12'd500; ypos = 12'd50;
        click(1'b0, 1'b1, 1'b0, 3, 2);
        check("low_y_act_b", 32'(act_b), 32'd3);
        check("low_y_pulses_b", 32'(cnt[1]), 32'd0);
        check("low_y_pulses_a", 32'(cnt[0]), 32'd1);
        ypos = 12'd2000;

        // Early release: a click two cycles after the first is accepted
        cnt = '{0, 0};
        set_btn(1'b0, 1'b1, 1'b0); cyc();
        set_btn(1'b0, 1'b0, 1'b0); cyc();
        set_btn(1'b0, 1'b1, 1'b0); cyc();
        set_btn(1'b0, 1'b0, 1'b0); repeat (2) cyc();
        check("fast_click_pulses_a", 32'(cnt[0]), 32'd2);

        // Asynchronous reset in the middle of a locked step
        set_btn(1'b0, 1'b1, 1'b0);
        cyc();
        rst = 1'b1;
        #2;
        check("arst_val_a1", 32'(value_a[23:12]), 32'd875);
        check("arst_val_b1", 32'(value_b[23:12]), 32'd2054);
        check("arst_pulse_a", 32'(pulse_a), 32'd0);
        check("arst_sat_b", 32'(sat_b), 32'd0);
        for (int d = 0; d < 2; d++) model_reset(d);
        set_btn(1'b0, 1'b0, 1'b0);
        repeat (2) cyc();
        rst = 1'b0;
        repeat (2) cyc();

        // Random traffic against the model
        repeat (300) begin
            xpos = 12'($urandom_range(0, 1199));
            ypos = 12'($urandom_range(0, 4095));
            lm   = 1'($urandom_range(0, 1));
            rm   = 1'($urandom_range(0, 1));
            mm   = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 14)) cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
